// File: rtl/btn_event_arbiter.sv
// Button event arbiter: edge detect, round-robin press arbitration,
// auto-repeat for the held key, and a small first-word fall-through event FIFO.
module btn_event_arbiter #(
  parameter int WIDTH         = 8,
  parameter int CODE_W        = $clog2(WIDTH),
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int DEPTH         = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WIDTH-1:0]  i_btn,
  output logic [CODE_W-1:0] o_code,
  output logic              o_repeat,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overflow
);

  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                           HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int FCNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LD  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  pending;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  gnt_vec;
  logic [CODE_W-1:0] rr_ptr;
  logic [CODE_W-1:0] gnt_code;
  logic              gnt_any;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic              req;
  logic              req_n;
  logic [CODE_W-1:0] held;
  logic [CODE_W-1:0] held_n;
  logic              rep_push;

  logic [CODE_W:0]   mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [CODE_W:0]   push_data;

  function automatic logic [CODE_W-1:0] wrap_idx(
    input logic [CODE_W-1:0] base,
    input int                k
  );
    int s;
    s = int'(base) + k;
    if (s >= WIDTH) s = s - WIDTH;
    return CODE_W'(s);
  endfunction

  assign rise  = i_btn & ~prev;
  assign full  = (count == FCNT_W'(DEPTH));
  assign empty = (count == '0);

  // Round-robin search for the next pending press after rr_ptr.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_code = '0;
    if (!full) begin
      for (int k = 1; k <= WIDTH; k++) begin
        if (!gnt_any && pending[wrap_idx(rr_ptr, k)]) begin
          gnt_any  = 1'b1;
          gnt_code = wrap_idx(rr_ptr, k);
        end
      end
    end
  end

  assign gnt_vec = WIDTH'(gnt_any) << gnt_code;

  // Edge history, pending presses, arbiter pointer and sticky overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev       <= '0;
      pending    <= '0;
      rr_ptr     <= CODE_W'(WIDTH - 1);
      o_overflow <= 1'b0;
    end else begin
      prev    <= i_btn;
      pending <= (pending & ~gnt_vec) | rise;
      if (gnt_any) rr_ptr <= gnt_code;
      if (|(rise & pending & ~gnt_vec)) o_overflow <= 1'b1;
    end
  end

  // Repeat FSM state and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= 1'b0;
      held  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      req   <= req_n;
      held  <= held_n;
    end
  end

  // Repeat FSM next state: a fresh grant overrides everything else.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req;
    held_n  = held;
    if (gnt_any) begin
      held_n  = gnt_code;
      state_n = DELAY;
      cnt_n   = HOLD_LD;
      req_n   = 1'b0;
    end else begin
      if (rep_push) req_n = 1'b0;
      case (state)
        IDLE: begin
        end
        DELAY: begin
          if (!i_btn[held]) begin
            state_n = IDLE;
            req_n   = 1'b0;
          end else if (cnt == '0) begin
            state_n = REPEAT;
            req_n   = 1'b1;
            cnt_n   = REP_LD;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!i_btn[held]) begin
            state_n = IDLE;
            req_n   = 1'b0;
          end else if (cnt == '0) begin
            req_n = 1'b1;
            cnt_n = REP_LD;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          req_n   = 1'b0;
        end
      endcase
    end
  end

  // Repeat FSM output: queue a repeat only when no press wants the slot.
  always_comb begin
    rep_push = req & ~gnt_any & ~full;
  end

  assign push      = gnt_any | rep_push;
  assign pop       = ~empty & i_ready;
  assign push_data = gnt_any ? {1'b0, gnt_code} : {1'b1, held};

  // Event storage; contents are only observed while count is non-zero.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_valid  = ~empty;
  assign o_code   = empty ? '0 : mem[rd_ptr][CODE_W-1:0];
  assign o_repeat = empty ? 1'b0 : mem[rd_ptr][CODE_W];

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Turns a vector of debounced button levels into a single ordered stream of key events. Each event carries a key code and a repeat flag. Presses on several buttons are shared onto one output channel by a round-robin arbiter. The held key generates auto-repeat events, and events are buffered in a small FIFO. The block sits between the button debouncer and the calculator's input decoder, which consumes events over a valid/ready handshake.

## Interface
- WIDTH, 8: number of buttons. Must be ≥ 2.
- CODE_W, $clog2(WIDTH): key code width.
- HOLD_CYCLES, 25_000_000: cycles a key must be held before the first repeat.
- REPEAT_CYCLES, 5_000_000: cycles between repeats.
- DEPTH, 4: FIFO entries. Must be a power of 2, ≥ 2.
- i_clk  in  1  system clock; all state updates on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_btn  in  WIDTH  debounced button levels, 1 = pressed. Synchronous to i_clk.
- o_code  out  CODE_W  key code (bit index) of the FIFO head.
- o_repeat  out  1  head event is an auto-repeat (1) or a fresh press (0).
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  consumer accepts the head event this cycle.
- o_overflow  out  1  sticky flag: a press was lost.

## Operation
- **Reset state** (applied immediately on i_rst high):
  - prev = 0, pending = 0, rr_ptr = WIDTH-1.
  - FIFO empty; count = 0.
  - state = IDLE; counter = 0; repeat_req = 0; held = 0.
  - o_valid = 0, o_code = 0, o_repeat = 0, o_overflow = 0.
  - Because prev resets to 0, a button held through reset yields one press event after reset is released.
- **Edge detect:** prev <= i_btn every cycle; rise = i_btn & ~prev.
- **Pending:**
  - pending bit i is set on rise[i] and cleared when bit i is granted.
  - If rise[i] arrives while pending[i] is already 1 (and not being granted that cycle), set o_overflow. The press is merged.
  - o_overflow stays 1 until reset.
- **Arbiter:**
  - Each cycle with count < DEPTH and pending ≠ 0, grant exactly one bit.
  - Search starts at rr_ptr+1 and wraps modulo WIDTH.
  - Push {repeat=0, code=i}, then set rr_ptr <= i and clear pending[i].
  - The full check uses count before any same-cycle pop, so a full FIFO popping this cycle accepts no push.
- **Repeat FSM**, states IDLE / DELAY / REPEAT:
  - **Any state, press granted for code c:**
    - held <= c; state <= DELAY; counter <= HOLD_CYCLES-1; repeat_req <= 0.
    - A newer press replaces the held key.
  - **DELAY/REPEAT, i_btn[held] = 0:** state <= IDLE; repeat_req <= 0. A grant in the same cycle takes precedence.
  - **DELAY, counter = 0:** repeat_req <= 1; state <= REPEAT; counter <= REPEAT_CYCLES-1.
  - **REPEAT, counter = 0:**
    - repeat_req <= 1; counter <= REPEAT_CYCLES-1.
    - If the previous request is still unqueued, it is silently dropped. Repeats are lossy and never set o_overflow.
  - **Otherwise:** counter decrements.
- **Repeat enqueue:**
  - Occurs when repeat_req = 1, no press grant is made this cycle, and count < DEPTH.
  - Pushes {repeat=1, code=held} and clears repeat_req.
  - Presses always win over repeats.
- **FIFO:**
  - First-word fall-through. o_code/o_repeat show the head entry and are forced to 0 when empty.
  - Pop occurs when o_valid & i_ready.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - Storage needs no reset.
- **Widths:** counter is $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)) bits.

## Timing
- **Press latency:**
  - Rise sampled at edge k → pending at k → grant/push at k+1 → o_valid high after k+1 (FIFO empty, no competing pending bits).
  - Each additional pending bit ahead in round-robin order adds 1 cycle.
- **First repeat:**
  - Grant at edge g → expiry at g+HOLD_CYCLES → push at g+HOLD_CYCLES+1 when uncontested.
  - Further repeats follow every REPEAT_CYCLES.
  - Contention or a full FIFO delays a repeat but does not shift the repeat period.
- **Pop:** o_valid/o_code update on the edge after the accepting cycle. Back-to-back pops run at 1 event/cycle.
- **Reset:** asynchronous assertion clears outputs without waiting for a clock edge. Deassertion is synchronized externally.

## Test plan
Parameters for all tests: WIDTH=4, HOLD_CYCLES=8, REPEAT_CYCLES=4, DEPTH=4.
- **Single press:** i_ready=1; raise i_btn[2] at edge k, hold 5 cycles, release → exactly one event: o_valid for 1 cycle after edge k+1, o_code=2, o_repeat=0. No repeats.
- **Simultaneous press, order from reset:** i_ready=0; raise bits 0, 1, 3 together → after 3 cycles count=3. Raise i_ready → events read out in order 0, 1, 3, all with o_repeat=0.
- **Round robin:** after a grant of code 1, pending = {0, 3} in the same cycle → 3 is pushed before 0.
- **Auto-repeat:** i_ready=1; hold i_btn[1] for 30 cycles.
  - Press event after g; repeats (o_repeat=1, code 1) after g+9, g+13, g+17, g+21, g+25, g+29.
  - Release → no further events.
- **Overflow:** i_ready=0; fill FIFO with 4 presses. Press bit 0 again, then release and press it a second time while still pending → o_overflow=1 and stays 1 after draining. One merged code-0 event is delivered.
- **Reset mid-operation:** FIFO holds 3 entries, o_overflow=1, FSM in REPEAT; pulse i_rst between edges.
  - o_valid=0, o_code=0, o_overflow=0 immediately.
  - After release, a still-held button produces one press event.
